// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared types, token geometry helpers and ODE header field widths
package rle_pkg;

    // Token layout helpers: one value bit above RUN_W run-length bits.
    function automatic int tok_w(input int run_w);
        return run_w + 1;
    endfunction

    function automatic int max_run(input int run_w);
        return (1 << run_w) - 1;
    endfunction

    // Field widths of the ODE solver load header.
    localparam int N_W    = 6;
    localparam int M_W    = 6;
    localparam int MODE_W = 1;
    localparam int H_W    = 16;
    localparam int TOL_W  = 16;
    localparam int FXP_W  = 2;
    localparam int CNT_W  = 4;
    localparam int ELEM_W = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } unpack_state_t;

endpackage

// File: rtl/rle_field_unpacker_if.sv
// rtl/rle_field_unpacker_if.sv - word input and field output handshakes of the unpacker
interface rle_field_unpacker_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 64
);
    localparam int LEN_W = $clog2(OUT_W + 1);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [LEN_W-1:0] fld_len;
    logic             fld_signed;
    logic             fld_valid;
    logic             fld_ready;
    logic [OUT_W-1:0] fld_data;

    // Host / sequencer side.
    modport master (
        output in_valid, in_data, fld_len, fld_signed, fld_ready,
        input  in_ready, fld_valid, fld_data
    );

    // Unpacker side.
    modport slave (
        input  in_valid, in_data, fld_len, fld_signed, fld_ready,
        output in_ready, fld_valid, fld_data
    );

endinterface

// File: rtl/rle_bit_buffer.sv
// rtl/rle_bit_buffer.sv - left-aligned bit buffer with same-cycle extract and run append
module rle_bit_buffer #(
    parameter int BUF_W = 128,
    parameter int OUT_W = 64,
    parameter int RUN_W = 3,
    parameter int LEN_W = $clog2(OUT_W + 1),
    parameter int LVL_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ext_en,
    input  logic [LEN_W-1:0] ext_len,
    input  logic             app_en,
    input  logic             app_bit,
    input  logic [RUN_W-1:0] app_run,
    output logic [LVL_W-1:0] level,
    output logic [OUT_W-1:0] top_bits
);
    localparam logic [LVL_W-1:0] BUF_W_L = LVL_W'(BUF_W);

    logic [BUF_W-1:0] bits_q;
    logic [BUF_W-1:0] bits_d;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] run_ones;
    logic [BUF_W-1:0] run_mask;
    logic [LVL_W-1:0] lvl_q;
    logic [LVL_W-1:0] lvl_d;
    logic [LVL_W-1:0] lvl_mid;
    logic [LVL_W-1:0] app_len;
    logic [LVL_W-1:0] shamt;

    // Extract first (shift out the field), then drop the run just below the reduced level.
    always_comb begin
        shifted  = ext_en ? (bits_q << ext_len) : bits_q;
        lvl_mid  = ext_en ? (lvl_q - LVL_W'(ext_len)) : lvl_q;
        app_len  = app_en ? LVL_W'(app_run) : '0;
        shamt    = BUF_W_L - lvl_mid - app_len;
        run_ones = (BUF_W'(1) << app_len) - BUF_W'(1);
        run_mask = run_ones << shamt;
        bits_d   = app_bit ? (shifted | run_mask) : (shifted & ~run_mask);
        lvl_d    = lvl_mid + app_len;
    end

    // Buffer and level registers; bits below the level are always kept at zero.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            bits_q <= '0;
            lvl_q  <= '0;
        end else begin
            bits_q <= bits_d;
            lvl_q  <= lvl_d;
        end
    end

    assign level    = lvl_q;
    assign top_bits = bits_q[BUF_W-1 -: OUT_W];

endmodule

// File: rtl/rle_field_unpacker.sv
// rtl/rle_field_unpacker.sv - run-length token decoder and field extractor (option: RLE_UNPACK_SIGN_EXT_EN)
module rle_field_unpacker
    import rle_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int RUN_W = 3,
    parameter int OUT_W = 64,
    parameter int BUF_W = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    rle_field_unpacker_if.slave          bus,
    output logic [$clog2(BUF_W+1)-1:0]   level,
    output logic                         busy,
    output logic                         err
);
    localparam int TOK_W   = tok_w(RUN_W);
    localparam int MAX_RUN = max_run(RUN_W);
    localparam int N_TOK   = IN_W / TOK_W;
    localparam int LEN_W   = $clog2(OUT_W + 1);
    localparam int LVL_W   = $clog2(BUF_W + 1);
    localparam int IDX_W   = (N_TOK > 1) ? $clog2(N_TOK) : 1;

    localparam logic [LVL_W-1:0] ROOM_NEED = LVL_W'(N_TOK * MAX_RUN);
    localparam logic [LVL_W-1:0] BUF_W_L   = LVL_W'(BUF_W);
    localparam logic [LEN_W-1:0] OUT_W_L   = LEN_W'(OUT_W);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_TOK - 1);

    unpack_state_t    state_q;
    unpack_state_t    state_d;
    logic [IN_W-1:0]  word_q;
    logic [IDX_W-1:0] idx_q;
    logic             accept;
    logic             app_en;
    logic             ext_en;
    logic             len_ok;
    logic [TOK_W-1:0] cur_tok;
    logic [OUT_W-1:0] top_bits;
    logic [OUT_W-1:0] aligned;
    logic [OUT_W-1:0] len_mask;
    logic [OUT_W-1:0] fld_out;

    // A word is only taken when the whole worst-case expansion is guaranteed to fit.
    assign bus.in_ready = (state_q == ST_IDLE) && !flush && !rst
                        && ((BUF_W_L - level) >= ROOM_NEED);
    assign accept       = bus.in_valid && bus.in_ready;

    assign len_ok        = (bus.fld_len != '0) && (bus.fld_len <= OUT_W_L);
    assign bus.fld_valid = len_ok && (level >= LVL_W'(bus.fld_len));
    assign ext_en        = bus.fld_valid && bus.fld_ready && !flush;

    // The token in flight is always the top slice of the latched word.
    assign cur_tok = word_q[IN_W-1 -: TOK_W];
    assign busy    = (state_q == ST_EXPAND);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and append strobe; flush abandons any word still being expanded.
    always_comb begin
        state_d = state_q;
        app_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                app_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            app_en  = 1'b0;
        end
    end

    // Latch the accepted word and step through its tokens, oldest first.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            word_q <= bus.in_data;
            idx_q  <= '0;
        end else if (app_en) begin
            word_q <= word_q << TOK_W;
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    // Sticky flag for an oversized field request.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            err <= 1'b0;
        end else if (bus.fld_len > OUT_W_L) begin
            err <= 1'b1;
        end
    end

    rle_bit_buffer #(
        .BUF_W (BUF_W),
        .OUT_W (OUT_W),
        .RUN_W (RUN_W),
        .LEN_W (LEN_W),
        .LVL_W (LVL_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .ext_en   (ext_en),
        .ext_len  (bus.fld_len),
        .app_en   (app_en),
        .app_bit  (cur_tok[TOK_W-1]),
        .app_run  (cur_tok[RUN_W-1:0]),
        .level    (level),
        .top_bits (top_bits)
    );

    // Right-align the top fld_len bits and optionally replicate the field's sign bit.
    always_comb begin
        aligned  = top_bits >> (OUT_W_L - bus.fld_len);
        len_mask = ~({OUT_W{1'b1}} << bus.fld_len);
        fld_out  = aligned & len_mask;
`ifdef RLE_UNPACK_SIGN_EXT_EN
        if (bus.fld_signed && len_ok && top_bits[OUT_W-1]) begin
            fld_out = aligned | ~len_mask;
        end
`endif
        if (!len_ok) begin
            fld_out = '0;
        end
    end

`ifndef RLE_UNPACK_SIGN_EXT_EN
    logic unused_fld_signed;
    assign unused_fld_signed = bus.fld_signed;
`endif

    assign bus.fld_data = fld_out;

endmodule
